// File: rtl/bsg_chip_mem_mux.sv
// Round-robin N:1 memory command mux with in-order response routing via a tag FIFO.
// Optional per-channel grant counters are enabled by defining BSG_CHIP_MEM_MUX_PERF_EN.
module bsg_chip_mem_mux #(
   parameter int num_ch_p          = 2,
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [num_ch_p*msg_width_p-1:0]       mem_cmd_i,
   input  logic [num_ch_p-1:0]                   mem_cmd_v_i,
   output logic [num_ch_p-1:0]                   mem_cmd_yumi_o,
   output logic [msg_width_p-1:0]                mem_resp_o,
   output logic [num_ch_p-1:0]                   mem_resp_v_o,
   input  logic [num_ch_p-1:0]                   mem_resp_ready_i,
   output logic [msg_width_p-1:0]                mem_cmd_o,
   output logic                                  mem_cmd_v_o,
   input  logic                                  mem_cmd_ready_i,
   input  logic [msg_width_p-1:0]                mem_resp_i,
   input  logic                                  mem_resp_v_i,
   output logic                                  mem_resp_yumi_o,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                  error_o,
   output logic [num_ch_p*32-1:0]                grant_count_o
);

   localparam int id_w  = $clog2(num_ch_p);
   localparam int ptr_w = $clog2(max_outstanding_p);
   localparam int cnt_w = $clog2(max_outstanding_p+1);

   logic [id_w-1:0]     p_q;
   logic [id_w-1:0]     winner;
   logic                found;
   int                  idx;
   logic                tag_full, tag_empty, grant, resp_ok;
   logic [id_w-1:0]     tag_mem [max_outstanding_p];
   logic [ptr_w-1:0]    rd_ptr_q, wr_ptr_q;
   logic [cnt_w-1:0]    cnt_q;
   logic [id_w-1:0]     head;
   logic                error_q;

   assign tag_full  = (cnt_q == cnt_w'(max_outstanding_p));
   assign tag_empty = (cnt_q == '0);
   assign head      = tag_mem[rd_ptr_q];

   // Search upward from p with wrap-around; the first valid channel wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < num_ch_p; i++) begin
         idx = (int'(p_q) + i) % num_ch_p;
         if (!found && mem_cmd_v_i[idx]) begin
            found  = 1'b1;
            winner = id_w'(idx);
         end
      end
   end

   assign mem_cmd_v_o = ~reset_i & (|mem_cmd_v_i) & ~tag_full;
   assign grant       = mem_cmd_v_o & mem_cmd_ready_i;
   assign mem_cmd_o   = mem_cmd_i[winner*msg_width_p +: msg_width_p];
   assign resp_ok     = ~reset_i & mem_resp_v_i & ~tag_empty;

   assign mem_resp_o      = mem_resp_i;
   assign mem_resp_yumi_o = resp_ok & mem_resp_ready_i[head];
   assign outstanding_o   = cnt_q;
   assign error_o         = error_q;

   always_comb begin
      mem_cmd_yumi_o = '0;
      mem_resp_v_o   = '0;
      if (grant)   mem_cmd_yumi_o[winner] = 1'b1;
      if (resp_ok) mem_resp_v_o[head]     = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         p_q      <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         if (grant) begin
            p_q      <= (winner == id_w'(num_ch_p-1)) ? '0 : winner + 1'b1;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (mem_resp_yumi_o) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (grant && !mem_resp_yumi_o)      cnt_q <= cnt_q + 1'b1;
         else if (!grant && mem_resp_yumi_o) cnt_q <= cnt_q - 1'b1;
         if (mem_resp_v_i && tag_empty) error_q <= 1'b1;
      end
   end

   // NOTE: tag storage is not reset; only the pointers and count decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (grant) tag_mem[wr_ptr_q] <= winner;
   end

`ifdef BSG_CHIP_MEM_MUX_PERF_EN
   logic [31:0] grant_cnt_q [num_ch_p];

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < num_ch_p; k++) begin
         if (reset_i)
            grant_cnt_q[k] <= '0;
         else if (mem_cmd_yumi_o[k] && grant_cnt_q[k] != 32'hFFFF_FFFF)
            grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
      end
   end

   for (genvar g = 0; g < num_ch_p; g++) begin : g_cnt
      assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
   end
`else
   assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chip_mem_mux.sv
// Self-checking bench for bsg_chip_mem_mux: directed table, corner sequences, random vs queue model.
module tb_bsg_chip_mem_mux;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int M  = 4;
   localparam int OW = $clog2(M+1);
`ifdef BSG_CHIP_MEM_MUX_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_i;
   logic [N*W-1:0] mem_cmd_i;
   logic [N-1:0]   mem_cmd_v_i, mem_cmd_yumi_o;
   logic [W-1:0]   mem_resp_o;
   logic [N-1:0]   mem_resp_v_o, mem_resp_ready_i;
   logic [W-1:0]   mem_cmd_o;
   logic           mem_cmd_v_o, mem_cmd_ready_i;
   logic [W-1:0]   mem_resp_i;
   logic           mem_resp_v_i, mem_resp_yumi_o;
   logic [OW-1:0]  outstanding_o;
   logic           error_o;
   logic [N*32-1:0] grant_count_o;

   bsg_chip_mem_mux #(.num_ch_p(N), .msg_width_p(W), .max_outstanding_p(M)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
      .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
      .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
      .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
      .outstanding_o(outstanding_o), .error_o(error_o), .grant_count_o(grant_count_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of channel ids in issue order plus a priority pointer.
   int          tagq[$];
   int          p_m = 0;
   bit          err_m = 1'b0;
   int unsigned gc_m[N];
   bit          exp_grant, exp_deq, exp_spur;
   int          w_m;

   typedef struct {
      logic [N-1:0]  v;
      logic          rv;
      logic [N-1:0]  rr;
      logic [N-1:0]  exp_yumi;
      logic          exp_cmd_v;
      logic [N-1:0]  exp_resp_v;
      logic          exp_resp_yumi;
      logic [OW-1:0] exp_out;
      logic          exp_err;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [N-1:0] rr);
      mem_cmd_v_i      = v;
      mem_cmd_ready_i  = rdy;
      mem_resp_v_i     = rv;
      mem_resp_ready_i = rr;
      #1;
   endtask

   // Compare every DUT output with the model for the inputs currently applied.
   task automatic eval_check();
      bit           found;
      logic [N-1:0] ey, erv;
      bit           ecv, eryumi;
      int           h;
      found = 1'b0;
      w_m   = 0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (p_m + i) % N;
         if (!found && mem_cmd_v_i[k]) begin found = 1'b1; w_m = k; end
      end
      ecv       = !reset_i && found && (tagq.size() < M);
      exp_grant = ecv && mem_cmd_ready_i;
      ey        = exp_grant ? N'(1) << w_m : '0;
      h         = (tagq.size() > 0) ? tagq[0] : 0;
      erv       = (!reset_i && mem_resp_v_i && tagq.size() > 0) ? N'(1) << h : '0;
      eryumi    = (erv != 0) && mem_resp_ready_i[h];
      exp_deq   = eryumi;
      exp_spur  = !reset_i && mem_resp_v_i && (tagq.size() == 0);
      check("cmd_v", mem_cmd_v_o, ecv);
      check("cmd_yumi", mem_cmd_yumi_o, ey);
      if (ecv) check("cmd_data", mem_cmd_o, mem_cmd_i[w_m*W +: W]);
      check("resp_v", mem_resp_v_o, erv);
      check("resp_yumi", mem_resp_yumi_o, eryumi);
      check("resp_data", mem_resp_o, mem_resp_i);
      check("outstanding", outstanding_o, tagq.size());
      check("error", error_o, err_m);
      for (int k = 0; k < N; k++)
         check("grant_count", grant_count_o[k*32 +: 32], PERF ? gc_m[k] : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_i) begin
         tagq.delete();
         p_m   = 0;
         err_m = 1'b0;
         for (int k = 0; k < N; k++) gc_m[k] = 0;
      end else begin
         if (exp_deq) void'(tagq.pop_front());
         if (exp_grant) begin
            tagq.push_back(w_m);
            p_m = (w_m + 1) % N;
            if (gc_m[w_m] != 32'hFFFF_FFFF) gc_m[w_m]++;
         end
         if (exp_spur) err_m = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      drive('1, 1'b1, 1'b1, '1);
      eval_check();
      tick();
      reset_i = 1'b0;
   endtask

   initial begin
      //            v      rv    rr     yumi    cv    resp_v  ry    out  err
      tbl[0]  = '{4'hF, 1'b0, 4'hF, 4'b0001, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{4'hF, 1'b0, 4'hF, 4'b0010, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b0};
      tbl[2]  = '{4'hF, 1'b0, 4'hF, 4'b0100, 1'b1, 4'b0000, 1'b0, 3'd2, 1'b0};
      tbl[3]  = '{4'hF, 1'b0, 4'hF, 4'b1000, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0};
      tbl[4]  = '{4'hF, 1'b0, 4'hF, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0};
      tbl[5]  = '{4'h8, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd4, 1'b0};
      tbl[6]  = '{4'h8, 1'b0, 4'hF, 4'b1000, 1'b1, 4'b0000, 1'b0, 3'd3, 1'b0};
      tbl[7]  = '{4'h0, 1'b0, 4'hF, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0};
      tbl[8]  = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b0010, 1'b1, 3'd4, 1'b0};
      tbl[9]  = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b0100, 1'b1, 3'd3, 1'b0};
      tbl[10] = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b1000, 1'b1, 3'd2, 1'b0};
      tbl[11] = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b1000, 1'b1, 3'd1, 1'b0};
      tbl[12] = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
      tbl[13] = '{4'h0, 1'b0, 4'hF, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1};

      for (int k = 0; k < N; k++) gc_m[k] = 0;
      mem_cmd_i  = '0;
      mem_resp_i = '0;
      reset_i    = 1'b1;
      drive('0, 1'b0, 1'b0, '0);
      tick();
      tick();
      do_reset();
      check("reset_outstanding", outstanding_o, 0);
      check("reset_error", error_o, 0);
      check("reset_grant_count", grant_count_o[63:0], 64'd0);

      // Round robin to full, full-with-dequeue, drain and spurious response.
      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < N; k++) mem_cmd_i[k*W +: W] = W'($urandom);
         mem_resp_i = W'($urandom);
         drive(tbl[i].v, 1'b1, tbl[i].rv, tbl[i].rr);
         eval_check();
         check($sformatf("tbl%0d_yumi", i), mem_cmd_yumi_o, tbl[i].exp_yumi);
         check($sformatf("tbl%0d_cmd_v", i), mem_cmd_v_o, tbl[i].exp_cmd_v);
         check($sformatf("tbl%0d_resp_v", i), mem_resp_v_o, tbl[i].exp_resp_v);
         check($sformatf("tbl%0d_resp_yumi", i), mem_resp_yumi_o, tbl[i].exp_resp_yumi);
         check($sformatf("tbl%0d_out", i), outstanding_o, tbl[i].exp_out);
         check($sformatf("tbl%0d_err", i), error_o, tbl[i].exp_err);
         tick();
      end
      drive('0, 1'b1, 1'b0, '1);
      check("error_sticky", error_o, 1'b1);
      do_reset();
      drive('0, 1'b1, 1'b0, '1);
      check("error_cleared", error_o, 1'b0);

      // Routing: ch2 issues A, ch0 issues B; responses return in that order.
      mem_cmd_i[2*W +: W] = 16'hAAAA;
      drive(4'b0100, 1'b1, 1'b0, '1);
      eval_check();
      check("route_grant_a", mem_cmd_yumi_o, 4'b0100);
      check("route_cmd_a", mem_cmd_o, 16'hAAAA);
      tick();
      mem_cmd_i[0 +: W] = 16'hBBBB;
      drive(4'b0001, 1'b1, 1'b0, '1);
      eval_check();
      check("route_grant_b", mem_cmd_yumi_o, 4'b0001);
      check("route_cmd_b", mem_cmd_o, 16'hBBBB);
      tick();
      mem_resp_i = 16'h1111;
      drive('0, 1'b1, 1'b1, '1);
      eval_check();
      check("route_r1_v", mem_resp_v_o, 4'b0100);
      check("route_r1_data", mem_resp_o, 16'h1111);
      tick();
      mem_resp_i = 16'h2222;
      drive('0, 1'b1, 1'b1, '1);
      eval_check();
      check("route_r2_v", mem_resp_v_o, 4'b0001);
      check("route_r2_data", mem_resp_o, 16'h2222);
      tick();

      // Backpressure on channel 1 for five cycles, then release.
      do_reset();
      drive(4'b0010, 1'b1, 1'b0, '1);
      eval_check();
      tick();
      for (int i = 0; i < 5; i++) begin
         drive('0, 1'b1, 1'b1, 4'b1101);
         eval_check();
         check("bp_yumi_low", mem_resp_yumi_o, 1'b0);
         check("bp_head_v", mem_resp_v_o, 4'b0010);
         check("bp_out", outstanding_o, 1);
         tick();
      end
      drive('0, 1'b1, 1'b1, '1);
      eval_check();
      check("bp_release_yumi", mem_resp_yumi_o, 1'b1);
      tick();
      drive('0, 1'b1, 1'b0, '1);
      eval_check();
      check("bp_drained", outstanding_o, 0);
      tick();

      // Ten grants to channel 1 with a response returned each following cycle.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(i < 10 ? 4'b0010 : 4'b0000, 1'b1, i > 0, '1);
         eval_check();
         tick();
      end
      drive('0, 1'b1, 1'b0, '1);
      check("perf_ch1_count", grant_count_o[63:32], PERF ? 32'd10 : 32'd0);
      check("perf_other_zero", {grant_count_o[127:64], grant_count_o[31:0]}, 64'd0);
`ifdef BSG_CHIP_MEM_MUX_PERF_EN
      dut.grant_cnt_q[2] = 32'hFFFF_FFFF;
      gc_m[2] = 32'hFFFF_FFFF;
      drive(4'b0100, 1'b1, 1'b0, '1);
      eval_check();
      tick();
      drive('0, 1'b1, 1'b0, '1);
      check("perf_saturate", grant_count_o[95:64], 32'hFFFF_FFFF);
`endif

      // Random traffic against the queue model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset_i = ($urandom_range(0, 299) == 0);
         for (int k = 0; k < N; k++) mem_cmd_i[k*W +: W] = W'($urandom);
         mem_resp_i = W'($urandom);
         drive(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, N'($urandom));
         eval_check();
         tick();
      end
      reset_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_chip_mem_mux.md
BSG_CHIP_MEM_MUX -- requirements
Module: bsg_chip_mem_mux

Interface
REQ-001 SHALL have parameter num_ch_p, default 2: number of requesting channels, 2..8.
REQ-002 SHALL have parameter msg_width_p, default 128: width of the opaque memory command and response messages.
REQ-003 SHALL have parameter max_outstanding_p, default 4: tag FIFO depth, power of two, 2..16.
REQ-004 SHALL have port clk_i, input, 1: sole clock.
REQ-005 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mem_cmd_i, input, num_ch_p*msg_width_p: per-channel commands; channel k occupies bits [k*msg_width_p +: msg_width_p].
REQ-007 SHALL have port mem_cmd_v_i, input, num_ch_p: per-channel command valid.
REQ-008 SHALL have port mem_cmd_yumi_o, output, num_ch_p: per-channel command consumed.
REQ-009 SHALL have port mem_resp_o, output, msg_width_p: response data, broadcast to all channels.
REQ-010 SHALL have port mem_resp_v_o, output, num_ch_p: per-channel response valid.
REQ-011 SHALL have port mem_resp_ready_i, input, num_ch_p: per-channel response ready.
REQ-012 SHALL have port mem_cmd_o, output, msg_width_p: downstream command.
REQ-013 SHALL have port mem_cmd_v_o, output, 1: downstream command valid.
REQ-014 SHALL have port mem_cmd_ready_i, input, 1: downstream ready.
REQ-015 SHALL have port mem_resp_i, input, msg_width_p: downstream response.
REQ-016 SHALL have port mem_resp_v_i, input, 1: downstream response valid.
REQ-017 SHALL have port mem_resp_yumi_o, output, 1: downstream response consumed.
REQ-018 SHALL have port outstanding_o, output, $clog2(max_outstanding_p+1): count of commands issued downstream and not yet returned.
REQ-019 SHALL have port error_o, output, 1: sticky flag, set when a response arrives with no command outstanding.
REQ-020 SHALL have port grant_count_o, output, num_ch_p*32: per-channel grant counters (see Configuration).

Function
REQ-021 SHALL drive mem_cmd_v_o = (|mem_cmd_v_i) & ~tag_full, combinationally, so the command path has zero cycles of latency.
REQ-022 SHALL select the round-robin winner among valid channels, searching upward from priority pointer p with wrap-around, and drive mem_cmd_o from that winner.
REQ-023 SHALL assert mem_cmd_yumi_o only for the winner, and only when mem_cmd_v_o & mem_cmd_ready_i; all other bits SHALL be 0.
REQ-024 SHALL, on each grant to channel k, update p to (k+1) mod num_ch_p; p SHALL stay unchanged when no grant occurs.
REQ-025 SHALL, on each grant, enqueue the winner's channel id into the in-order tag FIFO in the same cycle.
REQ-026 SHALL block grants while the FIFO is full, even if a dequeue occurs in the same cycle.
REQ-027 SHALL route each response to the FIFO head channel h: mem_resp_v_o[h] = mem_resp_v_i & ~tag_empty, with all other bits 0, and mem_resp_o = mem_resp_i.
REQ-028 SHALL assert mem_resp_yumi_o = mem_resp_v_i & ~tag_empty & mem_resp_ready_i[h], and dequeue the head on yumi.
REQ-029 SHALL provide no bypass: a tag enqueued in cycle t is dequeued no earlier than cycle t+1.
REQ-030 SHALL, on mem_resp_v_i while the FIFO is empty, hold mem_resp_yumi_o at 0, keep mem_resp_v_o at 0, and set error_o from the next cycle until reset.
REQ-031 SHALL keep outstanding_o unchanged on a simultaneous enqueue and dequeue; it SHALL otherwise increment on enqueue, decrement on dequeue, and never exceed max_outstanding_p.

Reset
REQ-032 SHALL, while reset_i is high at a clock edge, clear p to 0, empty the FIFO, set outstanding_o to 0, clear error_o and zero grant_count_o.
REQ-033 SHALL hold mem_cmd_yumi_o, mem_cmd_v_o, mem_resp_v_o and mem_resp_yumi_o at 0 during reset, regardless of inputs.
REQ-034 SHALL, when reset is asserted mid-operation, discard all in-flight tags; the environment is responsible for draining the downstream side.

Configuration
REQ-035 SHALL, when BSG_CHIP_MEM_MUX_PERF_EN is defined, implement one 32-bit counter per channel that increments on each grant and saturates at 0xFFFFFFFF, driven on grant_count_o.
REQ-036 SHALL, when BSG_CHIP_MEM_MUX_PERF_EN is undefined, drive grant_count_o constant 0 and instantiate no counter flops; all other behaviour SHALL be identical to the defined case.

Verification
REQ-037 Round-robin: num_ch_p=4, all channels valid, ready held high, responses never returned -> grants in order 0,1,2,3; grants then stop with outstanding_o=4 and mem_cmd_v_o=0.
REQ-038 Routing: channel 2 issues command A, then channel 0 issues command B; downstream returns R1 then R2 -> R1 presented with mem_resp_v_o=4'b0100, then R2 with 4'b0001.
REQ-039 Backpressure: response pending for channel 1 with mem_resp_ready_i[1]=0 for 5 cycles -> mem_resp_yumi_o=0 and head unchanged for those cycles; dequeued in the cycle ready rises.
REQ-040 Full with simultaneous dequeue: FIFO full, response accepted, channel 3 valid in the same cycle -> no grant that cycle; grant occurs next cycle; outstanding_o goes 4->3->4.
REQ-041 Spurious response: mem_resp_v_i=1 with the FIFO empty -> mem_resp_yumi_o=0 and error_o=1 from the next cycle; error_o is cleared only by reset.
REQ-042 Performance counters with BSG_CHIP_MEM_MUX_PERF_EN: 10 grants to channel 1 -> grant_count_o[63:32]=10; a counter preloaded to 0xFFFFFFFF stays at that value; with the macro undefined, grant_count_o reads all zeros.
